project1_button_pio_irq: RTL and testbench

//  Parametrised Avalon-MM input PIO for push buttons/switches: per-bit 2-FF

---
 rtl/project1_button_pio_irq.sv | 119 +++++++++++
 tb/tb_project1_button_pio_irq.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/project1_button_pio_irq.sv
// Avalon-MM input PIO for buttons: 2-FF sync, counter debounce,
// selectable edge capture with W1C flags and a maskable level irq.
module project1_button_pio_irq #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit INIT_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] INIT = {WIDTH{INIT_LEVEL}};

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0][CW-1:0] cnt;

  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_sel;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] cap_set;
  logic [WIDTH-1:0] cap_clr;
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  assign unused_wd = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= INIT;
      sync2 <= INIT;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // a bit is accepted once it has differed for DEBOUNCE_CYCLES cycles
  always_comb begin
    acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      acc[i] = (sync2[i] != deb[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign deb_nxt = deb ^ acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      deb <= INIT;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((sync2[i] == deb[i]) || acc[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      deb <= deb_nxt;
    end
  end

  assign wr_en   = chipselect & ~write_n;
  assign cap_set = acc & ~(deb_nxt ^ edge_sel);
  assign cap_clr = (wr_en && (address == 2'd3)) ?
                   writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
      edge_sel <= '0;
      edge_cap <= '0;
    end else begin
      if (wr_en && (address == 2'd1)) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      if (wr_en && (address == 2'd2)) begin
        edge_sel <= writedata[WIDTH-1:0];
      end
      // set beats a simultaneous clear
      edge_cap <= (edge_cap & ~cap_clr) | cap_set;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      2'd0: rd_mux = 32'(deb);
      2'd1: rd_mux = 32'(irq_mask);
      2'd2: rd_mux = 32'(edge_sel);
      2'd3: rd_mux = 32'(edge_cap);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_project1_button_pio_irq.sv
// Bench for project1_button_pio_irq: directed scenarios plus random
// stimulus against a sample-window reference model.
module tb_project1_button_pio_irq;

  localparam int W = 4;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata;
  logic          irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  project1_button_pio_irq #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .INIT_LEVEL(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  // model: a level is accepted when the last D synchronised samples
  // (pin values from 2..D+1 edges ago) all disagree with it
  logic [W-1:0] h [0:D];
  logic [W-1:0] m_deb, m_mask, m_sel, m_cap, m_rd;
  logic [W-1:0] t_acc, t_nd, t_clr;
  logic         m_irq;

  assign m_irq = |(m_cap & m_mask);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= D; k++) h[k] <= '1;
      m_deb  <= '1;
      m_mask <= '0;
      m_sel  <= '0;
      m_cap  <= '0;
      m_rd   <= '0;
    end else begin
      t_acc = '1;
      for (int k = 1; k <= D; k++) t_acc = t_acc & (h[k] ^ m_deb);
      t_nd = m_deb ^ t_acc;
      case (address)
        2'd0: m_rd <= m_deb;
        2'd1: m_rd <= m_mask;
        2'd2: m_rd <= m_sel;
        default: m_rd <= m_cap;
      endcase
      t_clr = '0;
      if (chipselect && !write_n && address == 2'd3) t_clr = writedata[W-1:0];
      if (chipselect && !write_n && address == 2'd1) m_mask <= writedata[W-1:0];
      if (chipselect && !write_n && address == 2'd2) m_sel <= writedata[W-1:0];
      m_cap <= (m_cap & ~t_clr) | (t_acc & ~(t_nd ^ m_sel));
      m_deb <= t_nd;
      for (int k = D; k >= 1; k--) h[k] <= h[k-1];
      h[0] <= in_port;
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp;
    reset      = 1'b1;
    in_port    = 4'hF;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL in_reset: rd=%h irq=%b want 0/0", readdata, irq);
    end
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      exp = (a == 0) ? 32'hF : 32'h0;
      checks++;
      if (d !== exp) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h want %h", a, d, exp);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    @(negedge clk);
    in_port = 4'hE;
    repeat (3) @(negedge clk);
    in_port = 4'hF;
    repeat (8) @(negedge clk);
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'hF) begin
      errors++;
      $display("FAIL glitch_data: got %h want %h", d, 32'hF);
    end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL glitch_cap: got %h want 0", d);
    end
  endtask

  task automatic test_accept();
    logic [31:0] d;
    logic [31:0] exp_d;
    logic        exp_i;
    bus_write(2'd1, 32'h1);
    @(negedge clk);
    address = 2'd0;
    in_port = 4'hE;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp_i = (k >= 6);
      exp_d = (k >= 7) ? 32'hE : 32'hF;
      checks++;
      if (irq !== exp_i) begin
        errors++;
        $display("FAIL accept_irq_e%0d: got %b want %b", k, irq, exp_i);
      end
      checks++;
      if (readdata !== exp_d) begin
        errors++;
        $display("FAIL accept_data_e%0d: got %h want %h", k, readdata, exp_d);
      end
    end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL accept_cap: got %h want 1", d);
    end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    bus_write(2'd3, 32'h1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL w1c_irq: got %b want 0", irq);
    end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL w1c_cap: got %h want 0", d);
    end
    @(negedge clk);
    in_port = 4'hF;
    repeat (8) @(negedge clk);
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL rise_ignored: got %h want 0", d);
    end
    @(negedge clk);
    in_port = 4'hE;
    repeat (5) @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 2'd3;
    writedata  = 32'h1;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL setwins_irq: got %b want 1", irq);
    end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL setwins_cap: got %h want 1", d);
    end
  endtask

  task automatic test_edgesel();
    logic [31:0] d;
    bus_write(2'd1, 32'h0);
    bus_write(2'd2, 32'h2);
    bus_write(2'd3, 32'hF);
    @(negedge clk);
    in_port = 4'hC;
    repeat (8) @(negedge clk);
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL sel_press_cap: got %h want 0", d);
    end
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'hC) begin
      errors++;
      $display("FAIL sel_press_data: got %h want %h", d, 32'hC);
    end
    in_port = 4'hE;
    repeat (8) @(negedge clk);
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL sel_release_cap: got %h want 2", d);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL sel_masked_irq: got %b want 0", irq);
    end
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 2'd1;
    writedata  = 32'h2;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL sel_unmask_irq: got %b want 1", irq);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [31:0] exp_d;
    @(negedge clk);
    in_port = 4'hF;
    repeat (12) @(negedge clk);
    in_port = 4'hE;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: rd=%h irq=%b want 0/0", readdata, irq);
    end
    reset   = 1'b0;
    address = 2'd0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp_d = (k >= 7) ? 32'hE : 32'hF;
      checks++;
      if (readdata !== exp_d) begin
        errors++;
        $display("FAIL mid_data_e%0d: got %h want %h", k, readdata, exp_d);
      end
    end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL mid_cap: got %h want 1", d);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL mid_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      checks++;
      if (readdata !== 32'(m_rd)) begin
        errors++;
        $display("FAIL rand_rd_%0d: got %h want %h", n, readdata, 32'(m_rd));
      end
      checks++;
      if (irq !== m_irq) begin
        errors++;
        $display("FAIL rand_irq_%0d: got %b want %b", n, irq, m_irq);
      end
      reset = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, 7) == 0) in_port[b] = ~in_port[b];
      end
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
    end
    @(negedge clk);
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_glitch();
    test_accept();
    test_w1c();
    test_edgesel();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
